// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: fetches one word, holds it while the datapath
// executes, then steps the PC (sequential, branch, jump or jr) or halts.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        adr_r31,
  input  logic [31:0] jr_target,
  input  logic        hold,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted
);

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t      state, state_next;
  logic        load_instr, load_pc;
  logic [31:0] next_pc, branch_off;

  // NOTE: state-holding logic uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load_instr = 1'b0;
    load_pc    = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ack) begin
          load_instr = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (!hold) begin
          if (opcode == OP_HALT) begin
            state_next = HALT;
          end else begin
            load_pc    = 1'b1;
            state_next = FETCH;
          end
        end
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      if (load_pc)    pc    <= next_pc;
      if (load_instr) instr <= imem_rdata;
    end
  end

  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  // jr wins over jump, jump over a taken branch; all sums wrap at 2^32.
  always_comb begin
    next_pc = pc_plus4;
    if (adr_r31)              next_pc = jr_target & 32'hFFFF_FFFC;
    else if (jump)            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && zero)  next_pc = pc_plus4 + branch_off;
  end

  // Handshake/status outputs come straight from the state register.
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == EXEC);
  assign halted      = (state == HALT);
  assign imem_addr   = pc;
  assign opcode      = instr[31:26];

endmodule
